// File: rtl/poco_pkg.sv
// Shared types and default sizing for the external RAM responder.
package poco_pkg;

  localparam int unsigned RAM_AW     = 8;
  localparam int unsigned RAM_DW     = 8;
  localparam int unsigned RAM_RD_LAT = 1;
  localparam int unsigned RD_CNT_W   = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_DRIVE,
    WR_HOLD,
    HOLD_OFF
  } state_e;

endpackage

// File: rtl/ram_responder_if.sv
// CPU-to-RAM strobe/address/status bundle; the bidirectional data bus stays a plain inout.
interface ram_responder_if
  import poco_pkg::*;
#(
  parameter int unsigned AW = RAM_AW
) ();

  logic [AW-1:0] addr;
  logic          r_ram;
  logic          w_ram;
  logic          rd_valid;
  logic          busy;
  logic          err_conflict;

  modport master (
    output addr, r_ram, w_ram,
    input  rd_valid, busy, err_conflict
  );

  modport slave (
    input  addr, r_ram, w_ram,
    output rd_valid, busy, err_conflict
  );

endinterface

// File: rtl/ram_core.sv
// Synchronous single-port array with a registered read port.
module ram_core #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  // Array contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_responder.sv
// Memory-side responder: one access per strobe assertion, fixed read latency,
// tri-state read drive gated live by the read strobe.
module ram_responder
  import poco_pkg::*;
#(
  parameter int unsigned AW     = RAM_AW,
  parameter int unsigned DW     = RAM_DW,
  parameter int unsigned RD_LAT = RAM_RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  ram_responder_if.slave    bus,
  inout  wire  [DW-1:0]     io_ram
);

  localparam logic [RD_CNT_W-1:0] CNT_LOAD = RD_CNT_W'(RD_LAT - 1);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [RD_CNT_W-1:0]   r_cnt;
  logic [RD_CNT_W-1:0]   w_cnt_nxt;
  logic [AW-1:0]         r_addr_q;
  logic [AW-1:0]         w_addr_nxt;
  logic                  r_err;
  logic                  w_err_nxt;
  logic                  w_we;
  logic                  w_re;
  logic [AW-1:0]         w_mem_addr;
  logic [DW-1:0]         w_rdata;
  logic                  w_oe;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_addr_q <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_addr_q <= w_addr_nxt;
      r_err    <= w_err_nxt;
    end
  end

  // Next state; the array is addressed from the bus only while idle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr_q;
    w_err_nxt   = r_err;
    w_we        = 1'b0;
    w_re        = 1'b0;
    w_mem_addr  = r_addr_q;

    case (r_state)
      IDLE: begin
        w_mem_addr = bus.addr;
        if (bus.r_ram && bus.w_ram) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = HOLD_OFF;
        end else if (bus.r_ram) begin
          w_addr_nxt  = bus.addr;
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = RD_WAIT;
        end else if (bus.w_ram) begin
          w_we        = 1'b1;
          w_state_nxt = WR_HOLD;
        end
      end
      RD_WAIT: begin
        if (!bus.r_ram) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == '0) begin
          w_re        = 1'b1;
          w_state_nxt = RD_DRIVE;
        end else begin
          w_cnt_nxt = r_cnt - RD_CNT_W'(1);
        end
      end
      RD_DRIVE: begin
        if (!bus.r_ram) w_state_nxt = IDLE;
      end
      WR_HOLD: begin
        if (!bus.w_ram) w_state_nxt = IDLE;
      end
      HOLD_OFF: begin
        if (!bus.r_ram && !bus.w_ram) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  ram_core #(
    .AW (AW),
    .DW (DW)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_addr  (w_mem_addr),
    .i_wdata (io_ram),
    .o_rdata (w_rdata)
  );

  // Drive enable follows r_ram combinationally so the bus frees in the cycle the strobe drops.
  assign w_oe             = (r_state == RD_DRIVE) && bus.r_ram;
  assign io_ram           = w_oe ? w_rdata : {DW{1'bz}};
  assign bus.rd_valid     = w_oe;
  assign bus.busy         = (r_state != IDLE);
  assign bus.err_conflict = r_err;

endmodule

// File: tb/tb_ram_responder.sv
// Randomized bench for ram_responder: two instances (read latency 1 and 3) against a memory model.
module tb_ram_responder;
  import poco_pkg::*;

  localparam int unsigned LAT0 = 1;
  localparam int unsigned LAT1 = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] r_addr [2];
  logic       r_rd   [2];
  logic       r_wr   [2];
  logic       r_oe   [2];
  logic [7:0] r_dat  [2];
  wire  [7:0] io0;
  wire  [7:0] io1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] mem     [2][256];
  bit         known   [2][256];
  bit         err_exp [2];

  always #5 clk = ~clk;

  // A released bus floats up to all ones.
  pullup (io0);
  pullup (io1);
  assign io0 = r_oe[0] ? r_dat[0] : 8'bz;
  assign io1 = r_oe[1] ? r_dat[1] : 8'bz;

  ram_responder_if ifc0 ();
  ram_responder_if ifc1 ();
  assign ifc0.addr  = r_addr[0];
  assign ifc0.r_ram = r_rd[0];
  assign ifc0.w_ram = r_wr[0];
  assign ifc1.addr  = r_addr[1];
  assign ifc1.r_ram = r_rd[1];
  assign ifc1.w_ram = r_wr[1];

  ram_responder #(.AW(8), .DW(8), .RD_LAT(LAT0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(ifc0), .io_ram(io0));
  ram_responder #(.AW(8), .DW(8), .RD_LAT(LAT1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(ifc1), .io_ram(io1));

  function automatic int unsigned lat_of(input int s);
    return (s == 0) ? LAT0 : LAT1;
  endfunction
  function automatic logic [7:0] io_of(input int s);
    return (s == 0) ? io0 : io1;
  endfunction
  function automatic logic valid_of(input int s);
    return (s == 0) ? ifc0.rd_valid : ifc1.rd_valid;
  endfunction
  function automatic logic busy_of(input int s);
    return (s == 0) ? ifc0.busy : ifc1.busy;
  endfunction
  function automatic logic err_of(input int s);
    return (s == 0) ? ifc0.err_conflict : ifc1.err_conflict;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_idle_bus(input int s, input string tag);
    chk($sformatf("%s%0d_valid", tag, s), 32'(valid_of(s)), 32'd0);
    chk($sformatf("%s%0d_bus", tag, s), 32'(io_of(s)), 32'hFF);
  endtask

  // Write with optional extra hold cycles, optionally raising r_ram during the hold.
  task automatic do_write(input int s, input logic [7:0] a, input logic [7:0] d,
                          input int hold, input bit rd_noise);
    r_addr[s] = a; r_dat[s] = d; r_oe[s] = 1'b1; r_wr[s] = 1'b1;
    cyc();
    r_oe[s] = 1'b0;
    mem[s][a] = d; known[s][a] = 1'b1;
    chk($sformatf("wr%0d_busy", s), 32'(busy_of(s)), 32'd1);
    for (int i = 0; i < hold; i++) begin
      r_addr[s] = 8'($urandom);
      if (rd_noise) r_rd[s] = 1'b1;
      #1;
      chk_idle_bus(s, "wrhold");
      chk($sformatf("wrhold%0d_err", s), 32'(err_of(s)), 32'(err_exp[s]));
      cyc();
      chk($sformatf("wrhold%0d_busy", s), 32'(busy_of(s)), 32'd1);
    end
    r_wr[s] = 1'b0; r_rd[s] = 1'b0;
    cyc();
    chk($sformatf("wr%0d_done", s), 32'(busy_of(s)), 32'd0);
  endtask

  // Hold r_ram for ncyc edges after acceptance; data must appear from edge lat onward.
  task automatic do_read(input int s, input logic [7:0] a, input int ncyc, input bit wr_noise);
    logic [7:0] e;
    bit drv;
    e = mem[s][a];
    r_addr[s] = a; r_rd[s] = 1'b1;
    for (int j = 0; j < ncyc; j++) begin
      cyc();
      drv = (j >= int'(lat_of(s)));
      chk($sformatf("rd%0d_busy", s), 32'(busy_of(s)), 32'd1);
      chk($sformatf("rd%0d_valid", s), 32'(valid_of(s)), 32'(drv));
      chk($sformatf("rd%0d_data", s), 32'(io_of(s)), drv ? 32'(e) : 32'hFF);
      r_addr[s] = 8'($urandom);
      if (wr_noise) r_wr[s] = 1'b1;
    end
    r_rd[s] = 1'b0; r_wr[s] = 1'b0;
    #1;
    chk_idle_bus(s, "rdrel");
    cyc();
    chk($sformatf("rd%0d_idle", s), 32'(busy_of(s)), 32'd0);
    chk($sformatf("rd%0d_err", s), 32'(err_of(s)), 32'(err_exp[s]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a;
    int s;
    bit found;
    for (int i = 0; i < 2; i++) begin
      r_addr[i] = '0; r_rd[i] = 1'b0; r_wr[i] = 1'b0; r_oe[i] = 1'b0; r_dat[i] = '0;
      err_exp[i] = 1'b0;
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst%0d_busy", i), 32'(busy_of(i)), 32'd0);
      chk($sformatf("rst%0d_err", i), 32'(err_of(i)), 32'd0);
      chk_idle_bus(i, "rst");
    end
    @(negedge clk);
    rst = 1'b1;
    cyc();

    // Read after write at both latencies, including the top address.
    do_write(0, 8'h10, 8'h5A, 0, 1'b0);
    do_read(0, 8'h10, 3, 1'b0);
    do_write(1, 8'hFF, 8'hC3, 0, 1'b0);
    do_read(1, 8'hFF, 5, 1'b0);

    // Only the first address/data of a held write strobe lands.
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++) do_write(i, 8'(8'h20 + k), 8'(8'hA0 + k), 0, 1'b0);
      r_wr[i] = 1'b1; r_oe[i] = 1'b1;
      for (int k = 0; k < 4; k++) begin
        r_addr[i] = 8'(8'h20 + k);
        r_dat[i]  = 8'(8'h11 * (k + 1));
        cyc();
      end
      r_wr[i] = 1'b0; r_oe[i] = 1'b0;
      cyc();
      mem[i][8'h20] = 8'h11;
      for (int k = 0; k < 4; k++) do_read(i, 8'(8'h20 + k), int'(lat_of(i)) + 1, 1'b0);
    end

    // Simultaneous strobes: sticky flag, no access, wait for both strobes low.
    r_addr[0] = 8'h10; r_dat[0] = 8'h99; r_oe[0] = 1'b1; r_rd[0] = 1'b1; r_wr[0] = 1'b1;
    cyc();
    r_oe[0] = 1'b0;
    err_exp[0] = 1'b1;
    #1;
    chk("cf_err", 32'(err_of(0)), 32'd1);
    chk("cf_busy", 32'(busy_of(0)), 32'd1);
    chk_idle_bus(0, "cf");
    r_wr[0] = 1'b0;
    cyc();
    chk("cf_hold", 32'(busy_of(0)), 32'd1);
    chk_idle_bus(0, "cfhold");
    r_rd[0] = 1'b0;
    cyc();
    chk("cf_release", 32'(busy_of(0)), 32'd0);
    cyc();
    chk("cf_sticky", 32'(err_of(0)), 32'd1);
    do_read(0, 8'h10, 2, 1'b0);
    chk("cf_other", 32'(err_of(1)), 32'd0);

    // Reads abandoned before the latency expires never drive.
    do_read(1, 8'hFF, 1, 1'b0);
    do_read(1, 8'hFF, 3, 1'b0);

    // Random mix, with cross-strobes during active accesses.
    for (int it = 0; it < 300; it++) begin
      s = int'($urandom_range(0, 1));
      found = 1'b0;
      a = '0;
      if ($urandom_range(0, 2) != 0) begin
        for (int t = 0; t < 64 && !found; t++) begin
          a = 8'($urandom);
          found = known[s][a];
        end
      end
      if (found) begin
        do_read(s, a, int'($urandom_range(1, lat_of(s) + 3)), 1'($urandom_range(0, 1)));
      end else begin
        do_write(s, 8'($urandom), 8'($urandom_range(0, 254)), int'($urandom_range(0, 2)),
                 1'($urandom_range(0, 1)));
      end
    end

    // Asynchronous reset in the middle of a read drive.
    r_addr[0] = 8'h10; r_rd[0] = 1'b1;
    cyc();
    cyc();
    chk("mr_valid", 32'(valid_of(0)), 32'd1);
    chk("mr_data", 32'(io0), 32'(mem[0][8'h10]));
    #2 rst = 1'b0;
    err_exp[0] = 1'b0;
    #1;
    chk_idle_bus(0, "mr");
    chk("mr_busy", 32'(busy_of(0)), 32'd0);
    chk("mr_err", 32'(err_of(0)), 32'd0);
    r_rd[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cyc();
    do_read(0, 8'h10, 2, 1'b0);
    do_read(1, 8'hFF, 4, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
- Memory-side responder for the CPU's external RAM port: decodes r_ram/w_ram, captures out_ram address and io_ram data on writes, drives io_ram on reads after a fixed latency.
- Sits on the board/top level opposite the CPU core, sharing its clock.
- Holds a 2^AW x DW array.
- Tracks access state so each strobe assertion performs exactly one access.

Parameters:
AW, 8, address width; must match the CPU's out_ram width.
DW, 8, data width; must match io_ram width.
RD_LAT, 1, rising edges from read acceptance to data drive; legal range 1..15.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-low reset; 0 clears all state.
addr  input  AW  RAM address from the CPU (out_ram).
io_ram  inout  DW  bidirectional data; driven only during a read data phase, otherwise high-Z.
r_ram  input  1  read strobe, active high, level held by the initiator.
w_ram  input  1  write strobe, active high, level held by the initiator.
rd_valid  output  1  high while io_ram carries valid read data.
busy  output  1  high in any state other than IDLE.
err_conflict  output  1  sticky flag: r_ram and w_ram were seen high together in IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, latency counter=0, rd_valid=0, busy=0, err_conflict=0.
  - io_ram released to Z immediately, not at the next edge.
  - Array contents are not cleared and are undefined after power-up.
- States: IDLE, RD_WAIT, RD_DRIVE, WR_HOLD, plus HOLD_OFF for the conflict case.
- IDLE, evaluated at each rising edge:
  - r_ram=1, w_ram=0: latch addr into addr_q, load counter with RD_LAT-1, go to RD_WAIT.
  - w_ram=1, r_ram=0: write array[addr] <= io_ram at this edge, go to WR_HOLD.
  - Both high: set err_conflict=1, perform no access, go to HOLD_OFF.
  - Neither high: stay in IDLE.
- RD_WAIT:
  - Counter=0: load data_q <= array[addr_q] and go to RD_DRIVE.
  - Otherwise decrement the counter.
  - r_ram falling to 0: abort to IDLE with no drive.
- RD_DRIVE:
  - io_ram = data_q when r_ram=1. The drive enable is combinationally gated by r_ram, so the bus releases in the same cycle r_ram falls.
  - rd_valid = (state==RD_DRIVE) & r_ram.
  - Stay while r_ram=1; go to IDLE on the first edge with r_ram=0.
  - Changes on addr during the read phase are ignored; a new address requires r_ram to deassert and reassert.
- WR_HOLD:
  - No further writes. Return to IDLE on the first edge with w_ram=0.
  - Holding w_ram with a changing addr or data writes nothing more.
- HOLD_OFF: return to IDLE only when r_ram=0 and w_ram=0.
- Read latency: with r_ram sampled at edge E0, data is driven after edge E0+RD_LAT.
- Addressing: full AW-bit decode with no wrap logic needed; address 2^AW-1 is a normal location.
- err_conflict clears only on reset.
- busy = (state != IDLE).
- A write strobe during a read state, or a read strobe during WR_HOLD, is ignored. The current access completes first, and err_conflict is not set.

Decomposition:
- Shared package poco_pkg holds:
  - the state enum {IDLE, RD_WAIT, RD_DRIVE, WR_HOLD, HOLD_OFF};
  - default constants RAM_AW=8, RAM_DW=8, RAM_RD_LAT=1.
- One sub-module, ram_core: the synchronous single-port array with write enable, write data, address and a registered read output.
- ram_responder contains the FSM, latency counter, conflict flag and tri-state driver.

Test Plan:
- RD_LAT=1 read after write:
  - Stimulus: w_ram=1, addr=0x10, io_ram=0x5A for 1 cycle, release; then r_ram=1, addr=0x10.
  - Required: io_ram=0x5A and rd_valid=1 after the 2nd edge from r_ram sampling; Z and rd_valid=0 in the same cycle r_ram falls.
- RD_LAT=3 timing:
  - Stimulus: write 0xC3 to 0xFF, then read 0xFF.
  - Required: io_ram stays Z for 3 edges, then reads 0xC3; busy=1 throughout.
- Write-once:
  - Stimulus: hold w_ram=1 for 4 cycles while addr steps 0x20..0x23 with data 0x11..0x44.
  - Required: only array[0x20]=0x11 is written; reads of 0x21..0x23 return their prior values.
- Conflict:
  - Stimulus: r_ram=w_ram=1 in IDLE.
  - Required: err_conflict=1 (sticky), io_ram Z, no write; state returns to IDLE only after both strobes are low; a subsequent read works.
- Reset mid-read:
  - Stimulus: rst=0 asynchronously during RD_DRIVE.
  - Required: io_ram Z and rd_valid=0 without waiting for a clock edge; busy=0; after rst=1, a fresh read returns the stored data.
- Read abort:
  - Stimulus: RD_LAT=3, r_ram drops after 1 cycle.
  - Required: no drive ever occurs; state returns to IDLE.
